// File: rtl/qpsk_pkg.sv
// ---------------------------------------------------------------------------
// qpsk_pkg
// Shared definitions for the QPSK modulator / demodulator pair.
//   - demod_state_t : demodulator control states (IDLE, RUN)
//   - BIT_POS/NEG   : symbol bit value that maps to a +1 / -1 carrier weight
//   - calc_sps      : samples (system clocks) per symbol
//   - sign_to_bit   : hard decision from the sign of a correlation
// ---------------------------------------------------------------------------
package qpsk_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } demod_state_t;

  // System-wide mapping: a 0 bit transmits +1 on its rail, a 1 bit transmits -1.
  localparam logic BIT_POS = 1'b0;
  localparam logic BIT_NEG = 1'b1;

  function automatic int calc_sps(input int clk_hz, input int sym_rate);
    return clk_hz / sym_rate;
  endfunction

  // A correlation of exactly zero is not negative, so it decides BIT_POS.
  function automatic logic sign_to_bit(input logic is_negative);
    return is_negative ? BIT_NEG : BIT_POS;
  endfunction

endpackage

// File: rtl/qpsk_nco.sv
// ---------------------------------------------------------------------------
// qpsk_nco
// 32-bit phase accumulator producing square-wave quadrature carrier signs.
// Ports:
//   clk, reset  : system clock, asynchronous active-low reset
//   clear       : synchronous phase reset to 0 (wins over en)
//   en          : advance phase by fcw on this edge
//   fcw         : frequency control word, phase step per clock
//   cos_neg     : 1 while the cosine reference is negative
//   sin_neg     : 1 while the sine reference is negative
// ---------------------------------------------------------------------------
module qpsk_nco (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        en,
  input  logic [31:0] fcw,
  output logic        cos_neg,
  output logic        sin_neg
);

  logic [31:0] phase;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase <= '0;
    end else if (clear) begin
      phase <= '0;
    end else if (en) begin
      phase <= phase + fcw;
    end
  end

  // Quadrants 1 and 2 have negative cosine, quadrants 2 and 3 negative sine.
  assign cos_neg = phase[31] ^ phase[30];
  assign sin_neg = phase[31];

endmodule

// File: rtl/qpsk_demodulator.sv
// ---------------------------------------------------------------------------
// qpsk_demodulator
// Coherent integrate-and-dump QPSK receiver for a 1-bit PDM line. The PDM
// stream is mixed with square I/Q references from qpsk_nco and summed over
// each symbol period; at the end of a symbol the sums are published as soft
// metrics together with a hard 2-bit decision and a weak-signal flag.
// Ports:
//   clk, reset   : system clock, asynchronous active-low reset
//   fcw          : NCO frequency control word
//   pdm_in       : received PDM bit (1 = +1, 0 = -1)
//   demod_en     : run enable; dropping it discards the partial symbol
//   sync         : one-cycle transmitter symbol boundary marker
//   symbol_out   : hard decision {I_bit, Q_bit}
//   symbol_valid : one-cycle strobe marking a new symbol on the outputs
//   soft_i/q     : signed I/Q correlations of the last symbol
//   symbol_weak  : either correlation magnitude below WEAK_THRESH
// ---------------------------------------------------------------------------
module qpsk_demodulator
  import qpsk_pkg::*;
#(
  parameter int SYSTEM_CLK_FREQ = 100_000_000,
  parameter int SYMBOL_RATE     = 1_000_000,
  parameter int ACC_W           = 16,
  parameter int WEAK_THRESH     = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [31:0]             fcw,
  input  logic                    pdm_in,
  input  logic                    demod_en,
  input  logic                    sync,
  output logic [1:0]              symbol_out,
  output logic                    symbol_valid,
  output logic signed [ACC_W-1:0] soft_i,
  output logic signed [ACC_W-1:0] soft_q,
  output logic                    symbol_weak
);

  localparam int SPS   = calc_sps(SYSTEM_CLK_FREQ, SYMBOL_RATE);
  localparam int CNT_W = (SPS > 2) ? $clog2(SPS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SPS - 1);
  localparam logic signed [ACC_W-1:0] THRESH    = ACC_W'(WEAK_THRESH);
  localparam logic signed [ACC_W-1:0] PLUS_ONE  = ACC_W'(1);
  localparam logic signed [ACC_W-1:0] MINUS_ONE = '1;

  // A full symbol of identical samples must fit in the signed accumulator.
  if (SPS < 2 || SPS > (2 ** (ACC_W - 1)) - 1) begin : g_bad_params
    $error("qpsk_demodulator: SPS out of range for ACC_W");
  end

  demod_state_t            state;
  logic [CNT_W-1:0]        cnt;
  logic signed [ACC_W-1:0] acc_i;
  logic signed [ACC_W-1:0] acc_q;

  logic                    cos_neg;
  logic                    sin_neg;
  logic                    nco_clear;
  logic                    nco_en;

  logic signed [ACC_W-1:0] sum_i;
  logic signed [ACC_W-1:0] sum_q;
  logic signed [ACC_W-1:0] mag_i;
  logic signed [ACC_W-1:0] mag_q;

  // Phase is held at zero while idle, and restarts on a sync or when the
  // receiver is being switched off, so the next symbol starts at phase 0.
  assign nco_clear = (state == IDLE) || !demod_en || sync;
  assign nco_en    = (state == RUN);

  qpsk_nco u_nco (
    .clk    (clk),
    .reset  (reset),
    .clear  (nco_clear),
    .en     (nco_en),
    .fcw    (fcw),
    .cos_neg(cos_neg),
    .sin_neg(sin_neg)
  );

  // Running sums including the sample taken on the current edge; these are
  // exactly the values published when this edge is the dump edge.
  assign sum_i = acc_i + ((pdm_in != cos_neg) ? PLUS_ONE : MINUS_ONE);
  assign sum_q = acc_q + ((pdm_in != sin_neg) ? PLUS_ONE : MINUS_ONE);
  assign mag_i = sum_i[ACC_W-1] ? -sum_i : sum_i;
  assign mag_q = sum_q[ACC_W-1] ? -sum_q : sum_q;

  // Control FSM with integrate-and-dump datapath. Priority inside RUN is
  // disable, then sync, then dump, so a sync on the dump edge kills the strobe.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      cnt          <= '0;
      acc_i        <= '0;
      acc_q        <= '0;
      symbol_out   <= '0;
      symbol_valid <= 1'b0;
      soft_i       <= '0;
      soft_q       <= '0;
      symbol_weak  <= 1'b0;
    end else begin
      symbol_valid <= 1'b0;
      case (state)
        IDLE: begin
          cnt   <= '0;
          acc_i <= '0;
          acc_q <= '0;
          if (demod_en) begin
            state <= RUN;
          end
        end
        RUN: begin
          if (!demod_en) begin
            state <= IDLE;
            cnt   <= '0;
            acc_i <= '0;
            acc_q <= '0;
          end else if (sync) begin
            cnt   <= '0;
            acc_i <= '0;
            acc_q <= '0;
          end else if (cnt == LAST_CNT) begin
            cnt          <= '0;
            acc_i        <= '0;
            acc_q        <= '0;
            soft_i       <= sum_i;
            soft_q       <= sum_q;
            symbol_out   <= {sign_to_bit(sum_i[ACC_W-1]), sign_to_bit(sum_q[ACC_W-1])};
            symbol_weak  <= (mag_i < THRESH) || (mag_q < THRESH);
            symbol_valid <= 1'b1;
          end else begin
            cnt   <= cnt + 1'b1;
            acc_i <= sum_i;
            acc_q <= sum_q;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_qpsk_demodulator.sv
// ---------------------------------------------------------------------------
// tb_qpsk_demodulator
// Self-checking bench for qpsk_demodulator: a table of constant-input
// vectors, hand-written sync / enable corner sequences, randomized PDM input
// checked by a queue-based reference model, and a loopback through a
// behavioural QPSK transmitter.
// ---------------------------------------------------------------------------
module tb_qpsk_demodulator;

  localparam int SPS    = 100;
  localparam int ACC_W  = 16;
  localparam int WEAK   = 16;
  localparam logic [31:0] LOOP_FCW = 32'd42949673;

  localparam int MODE_LOW    = 0;
  localparam int MODE_HIGH   = 1;
  localparam int MODE_TOGGLE = 2;
  localparam int MODE_RANDOM = 3;
  localparam int MODE_MANUAL = 4;

  logic                    clk      = 1'b0;
  logic                    reset    = 1'b0;
  logic [31:0]             fcw      = '0;
  logic                    pdm_in   = 1'b0;
  logic                    demod_en = 1'b0;
  logic                    sync     = 1'b0;
  logic [1:0]              symbol_out;
  logic                    symbol_valid;
  logic signed [ACC_W-1:0] soft_i;
  logic signed [ACC_W-1:0] soft_q;
  logic                    symbol_weak;

  int tests = 0;
  int fails = 0;
  int pdm_mode = MODE_LOW;

  qpsk_demodulator #(
    .SYSTEM_CLK_FREQ(100_000_000),
    .SYMBOL_RATE    (1_000_000),
    .ACC_W          (ACC_W),
    .WEAK_THRESH    (WEAK)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .fcw         (fcw),
    .pdm_in      (pdm_in),
    .demod_en    (demod_en),
    .sync        (sync),
    .symbol_out  (symbol_out),
    .symbol_valid(symbol_valid),
    .soft_i      (soft_i),
    .soft_q      (soft_q),
    .symbol_weak (symbol_weak)
  );

  always #5 clk = ~clk;

  // One comparison: counted, and reported on a single line when it fails.
  task automatic checkOutput(input string name, input longint actual, input longint expected);
    tests++;
    if (actual != expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Advance to the next falling edge, then drive pdm_in for the coming edge.
  task automatic applyStimulus();
    @(negedge clk);
    case (pdm_mode)
      MODE_LOW:    pdm_in = 1'b0;
      MODE_HIGH:   pdm_in = 1'b1;
      MODE_TOGGLE: pdm_in = ~pdm_in;
      MODE_RANDOM: pdm_in = 1'($urandom_range(0, 1));
      default:     ;
    endcase
  endtask

  // Step until a strobe is seen or the cycle budget expires.
  task automatic waitStrobe(input int limit, output int cycles);
    cycles = 0;
    do begin
      applyStimulus();
      cycles++;
    end while (!symbol_valid && cycles < limit);
  endtask

  task automatic checkSoft(input string tag, input int ei, input int eq,
                           input logic [1:0] es, input bit ew);
    checkOutput({tag, "_soft_i"}, longint'(soft_i), ei);
    checkOutput({tag, "_soft_q"}, longint'(soft_q), eq);
    checkOutput({tag, "_symbol"}, symbol_out, es);
    checkOutput({tag, "_weak"}, symbol_weak, ew);
  endtask

  // -------------------------------------------------------------------------
  // Reference model: samples are collected per symbol in queues and summed
  // when a full symbol's worth has been gathered.
  // -------------------------------------------------------------------------
  bit          m_run      = 1'b0;
  logic [31:0] m_phase    = '0;
  int          qi[$];
  int          qq[$];
  bit          exp_strobe = 1'b0;
  int          exp_i      = 0;
  int          exp_q      = 0;
  logic [1:0]  exp_sym    = '0;
  bit          exp_weak   = 1'b0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_run = 1'b0;
      m_phase = '0;
      qi.delete();
      qq.delete();
      exp_strobe = 1'b0;
    end else begin
      exp_strobe = 1'b0;
      if (!m_run) begin
        m_run = demod_en;
      end else if (!demod_en) begin
        m_run = 1'b0;
        m_phase = '0;
        qi.delete();
        qq.delete();
      end else if (sync) begin
        m_phase = '0;
        qi.delete();
        qq.delete();
      end else begin
        qi.push_back((pdm_in != (m_phase[31] ^ m_phase[30])) ? 1 : -1);
        qq.push_back((pdm_in != m_phase[31]) ? 1 : -1);
        m_phase = m_phase + fcw;
        if (qi.size() == SPS) begin
          exp_i = qi.sum();
          exp_q = qq.sum();
          exp_sym = {exp_i < 0, exp_q < 0};
          exp_weak = (exp_i < WEAK && exp_i > -WEAK) || (exp_q < WEAK && exp_q > -WEAK);
          exp_strobe = 1'b1;
          qi.delete();
          qq.delete();
        end
      end
    end
  end

  // Continuous comparison of every strobe (expected or produced) to the model.
  always @(negedge clk) begin
    if (reset && (exp_strobe || symbol_valid)) begin
      checkOutput("model_valid", symbol_valid, exp_strobe);
      if (exp_strobe) begin
        checkSoft("model", exp_i, exp_q, exp_sym, exp_weak);
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  typedef struct {
    logic [31:0] fcw;
    int          mode;
    int          exp_i;
    int          exp_q;
    logic [1:0]  exp_sym;
    bit          exp_weak;
  } vec_t;

  vec_t        vectors[3];
  int          cycles;
  int          received;
  int          lb_is, lb_qs, lb_cs, lb_ss, lb_v;
  logic [31:0] lb_phase;
  logic        lb_tie;
  logic [1:0]  lb_sym;
  logic [1:0]  txq[$];
  logic [1:0]  tx_expected;

  initial begin
    vectors[0] = '{32'd0, MODE_HIGH,    100,  100, 2'b00, 1'b0};
    vectors[1] = '{32'd0, MODE_LOW,    -100, -100, 2'b11, 1'b0};
    vectors[2] = '{32'd0, MODE_TOGGLE,    0,    0, 2'b00, 1'b1};

    // Reset state.
    repeat (3) @(negedge clk);
    checkSoft("reset", 0, 0, 2'b00, 1'b0);
    checkOutput("reset_valid", symbol_valid, 0);
    reset = 1'b1;
    applyStimulus();

    // Constant-input vectors: first-strobe latency, period and values.
    for (int v = 0; v < 3; v++) begin
      demod_en = 1'b0;
      repeat (2) applyStimulus();
      fcw = vectors[v].fcw;
      pdm_mode = vectors[v].mode;
      demod_en = 1'b1;
      waitStrobe(300, cycles);
      checkOutput($sformatf("vec%0d_latency", v), cycles, 101);
      checkSoft($sformatf("vec%0d_first", v), vectors[v].exp_i, vectors[v].exp_q,
                vectors[v].exp_sym, vectors[v].exp_weak);
      waitStrobe(300, cycles);
      checkOutput($sformatf("vec%0d_period", v), cycles, 100);
      checkSoft($sformatf("vec%0d_second", v), vectors[v].exp_i, vectors[v].exp_q,
                vectors[v].exp_sym, vectors[v].exp_weak);
    end

    // Sync in the middle of a symbol (cnt=40).
    demod_en = 1'b0;
    repeat (2) applyStimulus();
    fcw = '0;
    pdm_mode = MODE_HIGH;
    demod_en = 1'b1;
    waitStrobe(300, cycles);
    repeat (40) applyStimulus();
    sync = 1'b1;
    applyStimulus();
    sync = 1'b0;
    waitStrobe(300, cycles);
    checkOutput("sync_mid_latency", cycles + 1, 101);
    checkSoft("sync_mid", 100, 100, 2'b00, 1'b0);

    // Sync on the dump edge suppresses that strobe.
    repeat (99) applyStimulus();
    sync = 1'b1;
    applyStimulus();
    sync = 1'b0;
    checkOutput("sync_dump_no_strobe", symbol_valid, 0);
    waitStrobe(300, cycles);
    checkOutput("sync_dump_latency", cycles + 1, 101);

    // Disable at cnt=50: no strobe, outputs hold, restart from empty sums.
    repeat (50) applyStimulus();
    demod_en = 1'b0;
    waitStrobe(20, cycles);
    checkOutput("disable_no_strobe", symbol_valid, 0);
    checkSoft("idle_hold", 100, 100, 2'b00, 1'b0);
    pdm_mode = MODE_LOW;
    demod_en = 1'b1;
    waitStrobe(300, cycles);
    checkOutput("reenable_latency", cycles, 101);
    checkSoft("reenable", -100, -100, 2'b11, 1'b0);

    // Random PDM input and carrier, with occasional syncs and an fcw change.
    pdm_mode = MODE_RANDOM;
    fcw = $urandom;
    for (int i = 0; i < 600; i++) begin
      if (i == 300) fcw = $urandom;
      sync = ($urandom_range(0, 199) == 0);
      applyStimulus();
    end
    sync = 1'b0;

    // Loopback through a behavioural transmitter, tx = I*cos + Q*sin. The
    // zero-level periods are sent as alternating +1/-1 so they average out.
    pdm_mode = MODE_MANUAL;
    fcw = LOOP_FCW;
    sync = 1'b1;
    applyStimulus();
    sync = 1'b0;
    lb_phase = '0;
    lb_tie = 1'b0;
    received = 0;
    for (int s = 0; s < 20; s++) begin
      lb_sym = 2'($urandom_range(0, 3));
      txq.push_back(lb_sym);
      lb_is = lb_sym[1] ? -1 : 1;
      lb_qs = lb_sym[0] ? -1 : 1;
      for (int k = 0; k < SPS; k++) begin
        lb_cs = (lb_phase[31] ^ lb_phase[30]) ? -1 : 1;
        lb_ss = lb_phase[31] ? -1 : 1;
        lb_v = lb_is * lb_cs + lb_qs * lb_ss;
        if (lb_v > 0) pdm_in = 1'b1;
        else if (lb_v < 0) pdm_in = 1'b0;
        else begin
          pdm_in = lb_tie;
          lb_tie = ~lb_tie;
        end
        lb_phase = lb_phase + fcw;
        applyStimulus();
        if (symbol_valid) begin
          received++;
          tx_expected = (txq.size() > 0) ? txq.pop_front() : 2'bxx;
          checkOutput("loop_symbol", symbol_out, tx_expected);
          checkOutput("loop_soft_i_strong", (soft_i >= WEAK || soft_i <= -WEAK), 1);
          checkOutput("loop_soft_q_strong", (soft_q >= WEAK || soft_q <= -WEAK), 1);
          checkOutput("loop_weak", symbol_weak, 0);
        end
      end
    end
    checkOutput("loop_received", received, 20);

    // Asynchronous reset between clock edges clears outputs at once.
    #2;
    reset = 1'b0;
    #1;
    checkSoft("async_reset", 0, 0, 2'b00, 1'b0);
    checkOutput("async_reset_valid", symbol_valid, 0);
    @(negedge clk);
    reset = 1'b1;
    demod_en = 1'b0;
    repeat (2) applyStimulus();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/qpsk_demodulator.md
Name: qpsk_demodulator

Overview:
- Coherent receive-side counterpart of qpsk_modulator: takes the 1-bit PDM line, mixes it against square-wave I/Q carrier references from an internal NCO, and integrates-and-dumps over each symbol period.
- Emits one 2-bit hard symbol plus soft I/Q metrics per symbol.
- Sits between the analog comparator / PDM input pin and the framing / deframing logic.
- Symbol alignment to the transmitter is supplied externally via a sync pulse.

Parameters:
- SYSTEM_CLK_FREQ, 100_000_000: system clock in Hz.
- SYMBOL_RATE, 1_000_000: symbols per second. SPS = SYSTEM_CLK_FREQ/SYMBOL_RATE, integer, ≥ 2.
- ACC_W, 16: signed accumulator and soft-metric width. Elaboration error if SPS > 2^(ACC_W-1)-1.
- WEAK_THRESH, 16: the symbol is flagged weak when |acc_i| or |acc_q| < WEAK_THRESH.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- fcw  in  32  NCO frequency control word, same scaling as the modulator.
- pdm_in  in  1  received PDM bit; 1 = +1, 0 = -1.
- demod_en  in  1  run enable.
- sync  in  1  one-cycle pulse marking a transmitter symbol boundary.
- symbol_out  out  2  decided symbol {I_bit, Q_bit}.
- symbol_valid  out  1  one-cycle strobe; symbol_out / soft outputs are valid on this cycle.
- soft_i  out  ACC_W  signed I correlation of the last symbol.
- soft_q  out  ACC_W  signed Q correlation of the last symbol.
- symbol_weak  out  1  weak flag for the last symbol.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, phase=0, cnt=0, acc_i=acc_q=0. Outputs: symbol_out=0, symbol_valid=0, soft_i=soft_q=0, symbol_weak=0.
- Signal convention, system-wide: tx = I·cos + Q·sin, with I = +1 when symbol bit[1]=0 and Q = +1 when bit[0]=0.
- References come from phase[31:30]:
  - cos_neg = phase[31]^phase[30].
  - sin_neg = phase[31].
- Per-sample contribution:
  - I: +1 if pdm_in != cos_neg, else -1.
  - Q: +1 if pdm_in != sin_neg, else -1.
- FSM states are IDLE and RUN.
  - IDLE: hold phase=0, cnt=0, accumulators 0. demod_en=1 sampled → RUN. The first sample is taken at the next edge, using phase 0.
  - RUN: on every edge, accumulate the contribution, phase += fcw (mod 2^32), cnt += 1.
  - On the edge where cnt==SPS-1, a dump occurs:
    - soft_i/soft_q ← final sums, including this sample.
    - I_bit = (soft_i<0), Q_bit = (soft_q<0).
    - symbol_weak set as defined by WEAK_THRESH.
    - symbol_valid=1 for exactly the following cycle.
    - Accumulators → 0, cnt → 0. Phase keeps running.
  - RUN with demod_en=0: → IDLE next edge, partial symbol discarded, no strobe.
- Latency: the first symbol_valid is high SPS+1 cycles after demod_en is first sampled high. Subsequent strobes follow every SPS cycles.
- sync=1 in RUN: that edge takes no sample. phase=0, cnt=0, accumulators cleared.
  - Sync on the dump edge: sync wins, no strobe.
  - Sync in IDLE is ignored.
- A dump of acc exactly 0 decides bit 0, and is weak whenever WEAK_THRESH > 0.
- soft_*/symbol_out/symbol_weak hold their last values between strobes and across IDLE.
- An fcw change is used from the next edge, with no phase reset.
- Reset mid-symbol: immediate return to the reset values above; no strobe.

Decomposition:
- qpsk_pkg holds:
  - the state enum (IDLE, RUN).
  - a function for SPS.
  - symbol-mapping constants (bit→sign), shared with qpsk_modulator.
- Sub-module qpsk_nco:
  - phase accumulator with clear and enable.
  - outputs cos_neg/sin_neg.
  - reusable by the modulator.

Test Plan:
- fcw=0, pdm_in held 1, demod_en rises: symbol_valid 101 cycles later, then every 100 cycles. Each strobe gives soft_i=+100, soft_q=+100, symbol_out=2'b00, weak=0.
- fcw=0, pdm_in held 0: soft_i=soft_q=-100, symbol_out=2'b11.
- fcw=0, pdm_in toggling 1/0 each cycle: soft_i=soft_q=0, symbol_out=2'b00, symbol_weak=1.
- sync pulse at cnt=40 of a symbol: no strobe for that symbol. The next strobe comes 101 cycles after the sync edge (sync edge plus 100 samples, then the strobe cycle). Sync asserted on the dump edge suppresses that strobe.
- demod_en dropped at cnt=50: no strobe. Re-enable gives the first strobe after 101 cycles, with soft values from fresh accumulators only.
- Loopback with qpsk_modulator, fcw=42949673, random symbols, common sync at the modulator's symbol boundary:
  - every received symbol_out equals the transmitted symbol.
  - |soft_i| and |soft_q| ≥ WEAK_THRESH.
  - no weak flags.
  - asynchronous reset pulse mid-run clears all outputs to 0 immediately.
